// File: rtl/audio_pkg.sv
// Shared types for the audio return path: sample word and SPI transmit FSM states.
package audio_pkg;

  localparam int unsigned AUDIO_W = 16;

  typedef logic [AUDIO_W-1:0] audio_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with explicit level tracking so full and empty never alias.
module sample_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LevelFull);
  assign empty_o = (level_q == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/spi_audio_return.sv
// SPI mode-0 slave transmitter: drains buffered audio samples MSB first on MISO,
// one word per frame, with the MCU supplying sclk and an active-high select.
module spi_audio_return
  import audio_pkg::*;
#(
  parameter int unsigned clock_max   = 25_000_000,
  parameter int unsigned DATA_W      = AUDIO_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  input  logic                          sclk_in,
  input  logic                          active_in,
  output logic                          miso_out,
  output logic                          miso_oe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  // Shortest legal sclk half period in system clocks (sclk <= clock_max / 8).
  localparam int unsigned MinHalf = clock_max / (2 * (clock_max / 8));

  // Top bit of each pipe is the edge-detect register behind the synchronizer.
  logic [SYNC_STAGES:0] sclk_pipe_q, act_pipe_q;
  logic sclk_s, sclk_prev, act_s, act_prev;
  logic sclk_rise, sclk_fall, act_rise;

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CntW-1:0]   cnt_q;
  logic              reload_q;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      sclk_pipe_q <= '0;
      act_pipe_q  <= '0;
    end else begin
      sclk_pipe_q <= {sclk_pipe_q[SYNC_STAGES-1:0], sclk_in};
      act_pipe_q  <= {act_pipe_q[SYNC_STAGES-1:0], active_in};
    end
  end

  assign sclk_s    = sclk_pipe_q[SYNC_STAGES-1];
  assign sclk_prev = sclk_pipe_q[SYNC_STAGES];
  assign act_s     = act_pipe_q[SYNC_STAGES-1];
  assign act_prev  = act_pipe_q[SYNC_STAGES];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign act_rise  = act_s & ~act_prev;

  assign fifo_pop = (state_q == LOAD) & act_s;

  sample_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_25mhz),
    .rst_i   (reset),
    .push_i  (sample_valid),
    .wdata_i (sample_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
      // Deselect wins over everything; a partial word is simply dropped.
      if (!act_s) begin
        state_q  <= IDLE;
        reload_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (act_rise) state_q <= LOAD;
          LOAD: begin
            if (fifo_empty) begin
              shift_q  <= '0;
              underrun <= 1'b1;
            end else begin
              shift_q <= fifo_rdata;
            end
            cnt_q    <= '0;
            reload_q <= 1'b0;
            state_q  <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q == CntW'(DATA_W - 1)) begin
                frame_done <= 1'b1;
                reload_q   <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (reload_q) state_q <= LOAD;
              else          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso_oe  = act_s;
  assign miso_out = act_s & shift_q[DATA_W-1];

  // Cycles since the last synchronized sclk edge; only feeds the rate check below.
  logic [2:0] gap_q;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      gap_q <= '1;
    end else if (sclk_rise || sclk_fall) begin
      gap_q <= '0;
    end else if (gap_q != '1) begin
      gap_q <= gap_q + 3'd1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset && state_q == SHIFT && (sclk_rise || sclk_fall)) begin
      assert (32'(gap_q) >= MinHalf - 1);
    end
  end

endmodule

// File: tb/tb_spi_audio_return.sv
// Directed bench: the bench acts as the MCU, clocking sclk at 1 MHz against a 25 MHz system clock.
module tb_spi_audio_return;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sclk_in;
  logic        active_in;
  logic        miso_out;
  logic        miso_oe;
  logic [2:0]  fifo_level;
  logic        frame_done;
  logic        overflow;
  logic        underrun;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fd0;
  logic [31:0] w;

  always #20 clk_25mhz = ~clk_25mhz;

  spi_audio_return dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sclk_in      (sclk_in),
    .active_in    (active_in),
    .miso_out     (miso_out),
    .miso_oe      (miso_oe),
    .fifo_level   (fifo_level),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always @(negedge clk_25mhz) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    @(posedge clk_25mhz);
    #1 sample_in = d;
    sample_valid = 1'b1;
    @(posedge clk_25mhz);
    #1 sample_valid = 1'b0;
  endtask

  task automatic start_frame();
    active_in = 1'b1;
    #500;
  endtask

  // Samples MISO just before each rising edge; leaves sclk high after the last bit.
  task automatic shift_bits(input int n, output logic [31:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        sclk_in = 1'b0;
        #500;
      end
      word = {word[30:0], miso_out};
      sclk_in = 1'b1;
      #500;
    end
  endtask

  // Select and sclk drop together, so no extra reload is triggered at frame end.
  task automatic end_frame();
    active_in = 1'b0;
    sclk_in   = 1'b0;
    #500;
  endtask

  initial begin
    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    sclk_in = 1'b0;
    active_in = 1'b0;
    #103 reset = 1'b0;
    #20;
    check("rst_miso", 32'(miso_out), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_und", 32'(underrun), 32'd0);

    // Single frame
    push(16'hA5C3);
    check("t1_level1", 32'(fifo_level), 32'd1);
    fd0 = fd_cnt;
    start_frame();
    check("t1_oe", 32'(miso_oe), 32'd1);
    shift_bits(16, w);
    check("t1_word", w, 32'h0000_A5C3);
    end_frame();
    check("t1_level0", 32'(fifo_level), 32'd0);
    check("t1_done", 32'(fd_cnt - fd0), 32'd1);
    check("t1_und", 32'(underrun), 32'd0);
    check("t1_oe_off", 32'(miso_oe), 32'd0);
    check("t1_miso_off", 32'(miso_out), 32'd0);

    // Back-to-back frames with select held
    push(16'h1234);
    push(16'hFFFF);
    fd0 = fd_cnt;
    start_frame();
    shift_bits(32, w);
    end_frame();
    check("t2_words", w, 32'h1234_FFFF);
    check("t2_done", 32'(fd_cnt - fd0), 32'd2);
    check("t2_und", 32'(underrun), 32'd0);

    // Underrun
    start_frame();
    shift_bits(16, w);
    end_frame();
    check("t3_zero", w, 32'h0);
    check("t3_und", 32'(underrun), 32'd1);
    push(16'h8001);
    start_frame();
    shift_bits(16, w);
    end_frame();
    check("t3_word", w, 32'h0000_8001);
    check("t3_und_sticky", 32'(underrun), 32'd1);

    // Overflow
    check("t4_ovf_pre", 32'(overflow), 32'd0);
    for (int i = 1; i <= 6; i++) push(16'(i));
    check("t4_level", 32'(fifo_level), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      start_frame();
      shift_bits(16, w);
      end_frame();
      check($sformatf("t4_word%0d", i), w, 32'(i));
    end
    check("t4_level0", 32'(fifo_level), 32'd0);

    // Abort after 7 bits
    push(16'hF00F);
    push(16'h1111);
    fd0 = fd_cnt;
    start_frame();
    shift_bits(7, w);
    end_frame();
    check("t5_partial", w, 32'h78);
    start_frame();
    shift_bits(16, w);
    end_frame();
    check("t5_next", w, 32'h0000_1111);
    check("t5_done", 32'(fd_cnt - fd0), 32'd1);

    // Reset mid-frame
    push(16'hABCD);
    push(16'h5555);
    start_frame();
    shift_bits(9, w);
    check("t6_partial", w, 32'h157);
    reset = 1'b1;
    #1;
    check("t6_miso", 32'(miso_out), 32'd0);
    check("t6_oe", 32'(miso_oe), 32'd0);
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_done", 32'(frame_done), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_und", 32'(underrun), 32'd0);
    active_in = 1'b0;
    sclk_in = 1'b0;
    #100 reset = 1'b0;
    #100;
    start_frame();
    shift_bits(16, w);
    end_frame();
    check("t6_zero", w, 32'h0);
    check("t6_und_set", 32'(underrun), 32'd1);
    check("t6_ovf_clr", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
